// File: rtl/s38584_sched_pkg.sv
// s38584_sched_pkg: shared state encoding, default sizes and a clog2 helper
package s38584_sched_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, CMP, RESP} state_t;
    localparam int NREQ_DEF = 4;
    localparam int KW_DEF = 2;
    localparam int TO_CYCLES_DEF = 15;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/s38584_rr_arb.sv
// s38584_rr_arb: combinational round-robin pick, searching upward from ptr with wrap
module s38584_rr_arb import s38584_sched_pkg::*; #(
    parameter int NREQ = NREQ_DEF,
    parameter int PW = clog2(NREQ_DEF)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   idx,
    output logic            any
);
    always_comb begin
        win = '0;
        idx = '0;
        // walk the search order backwards so the closest request to ptr is assigned last
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % NREQ]) begin
                idx = PW'((int'(ptr) + i) % NREQ);
                win = NREQ'(1) << ((int'(ptr) + i) % NREQ);
            end
    end
    assign any = |req;
endmodule

// File: rtl/s38584_match_sched.sv
// s38584_match_sched: round-robin shared tag matcher; S38584_SCHED_TIMEOUT_EN adds a GRANT-wait timeout
module s38584_match_sched import s38584_sched_pkg::*; #(
    parameter int NREQ = NREQ_DEF,
    parameter int KW = KW_DEF,
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic             CK,
    input  logic             g35,
    input  logic             inhibit,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  tag_vld,
    input  logic [NREQ*KW-1:0] tag,
    input  logic             cfg_we,
    input  logic [KW-1:0]    cfg_ref,
    output logic [NREQ-1:0]  gnt,
    output logic             ack,
    output logic             hit,
    output logic             err,
    output logic [NREQ-1:0]  stat,
    output logic             busy
);
    localparam int PW = clog2(NREQ);
    state_t state, nxt;
    logic [PW-1:0] ptr, w, widx;
    logic [NREQ-1:0] win;
    logic [KW-1:0] ref_q, cap;
    logic any, start, abort, to, m, match, err_q;

    s38584_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req(req), .ptr(ptr), .win(win), .idx(widx), .any(any)
    );

    assign start = !inhibit && any;
    assign abort = !req[w];
    assign m = cap == ref_q;

`ifdef S38584_SCHED_TIMEOUT_EN
    localparam int TW = clog2(TO_CYCLES + 1);
    logic [TW-1:0] cnt;
    always_ff @(posedge CK)
        cnt <= (!g35 || state != GRANT) ? '0 : cnt + 1'b1;
    assign to = state == GRANT && cnt == TW'(TO_CYCLES);
`else
    assign to = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = start ? GRANT : IDLE;
            GRANT: nxt = abort ? RESP : tag_vld[w] ? CMP : to ? RESP : GRANT;
            CMP:   nxt = RESP;
            RESP:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!g35) begin
            state <= IDLE;
            gnt <= '0;
            ptr <= '0;
            w <= '0;
            cap <= '0;
            ref_q <= '0;
            match <= 1'b0;
            err_q <= 1'b0;
            stat <= '0;
        end else begin
            state <= nxt;
            if (cfg_we) ref_q <= cfg_ref;
            case (state)
                IDLE: if (start) begin
                    gnt <= win;
                    w <= widx;
                end
                GRANT: if (abort || (!tag_vld[w] && to)) begin
                    gnt <= '0;
                    err_q <= 1'b1;
                    match <= 1'b0;
                end else if (tag_vld[w]) cap <= tag[int'(w)*KW +: KW];
                // compare uses the pre-write ref, so a same-edge cfg_we is not seen
                CMP: begin
                    gnt <= '0;
                    err_q <= 1'b0;
                    match <= m;
                    if (m) stat[w] <= ~stat[w];
                end
                RESP: ptr <= (w == PW'(NREQ - 1)) ? '0 : w + 1'b1;
            endcase
        end
    end

    assign ack = state == RESP;
    assign hit = ack && match;
    assign err = ack && err_q;
    assign busy = state != IDLE;
endmodule

// File: doc/s38584_match_sched.md
Name: s38584_match_sched

Overview:
Round-robin scheduler that shares a single tag-match unit among NREQ requesters inside the s38584 control cone. It grants one requester at a time and waits for that requester's tag. It then compares the tag against a programmed reference pair, the same XOR-equality style used on g728/g661 and g655/g718. On a hit it toggles the requester's status bit, which is the hold/flip role g671/g676 play in the cone.

Parameters:
NREQ, 4, number of requesters (2..8)
KW, 2, tag width in bits
TO_CYCLES, 15, GRANT-wait timeout limit (used only with the optional feature)

Ports:
CK  input  1  clock, rising edge
g35  input  1  synchronous active-low reset, sampled on CK
inhibit  input  1  global block (g504/g528 style); while high, no new grant is issued
req  input  NREQ  request per requester, level
tag_vld  input  NREQ  tag valid per requester
tag  input  NREQ*KW  packed tags; requester i uses bits [i*KW +: KW]
cfg_we  input  1  reference write strobe
cfg_ref  input  KW  reference value
gnt  output  NREQ  one-hot grant, registered
ack  output  1  one-cycle completion pulse
hit  output  1  tag matched, valid only with ack
err  output  1  timeout or abort indication, valid only with ack
stat  output  NREQ  per-requester toggle status
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (g35=0 at CK): state IDLE; gnt=0, ack=0, hit=0, err=0, stat=0, busy=0; ref=0; rr pointer=0.
- Reset asserted mid-operation: all of the above take effect at that edge. No ack is issued for the aborted transaction.
- States: IDLE, GRANT, CMP, RESP.
- IDLE:
  - If inhibit=0 and any req bit is set, pick a winner by round-robin, searching from the rr pointer upward with wrap.
  - Next cycle: GRANT, with gnt set one-hot to the winner and busy=1.
  - inhibit=1 holds IDLE. inhibit has no effect in the other states.
- GRANT:
  - req[w]=0 → RESP with err=1, hit=0 (abort).
  - Otherwise tag_vld[w]=1 → capture tag[w] and go to CMP.
  - Otherwise stay in GRANT.
  - If req drop and tag_vld arrive in the same cycle, the abort wins.
- CMP:
  - Register match = (captured tag == ref), then go to RESP.
  - gnt stays asserted through CMP.
- RESP (one cycle):
  - ack=1; hit=match; gnt=0.
  - If hit=1, stat[w] toggles at that same edge.
  - rr pointer becomes (w+1) mod NREQ, for both hit and error outcomes.
  - Next state: IDLE.
- Latency: req sampled at edge t → gnt at t+1; tag_vld sampled at edge t+k → CMP at t+k+1 → ack at t+k+2. Minimum is 3 cycles from request to ack.
- Back-to-back: IDLE always lasts at least one cycle between transactions, so a requester re-asserting req is served again only after the others pending at that point.
- Reference writes: cfg_we loads ref at the edge in any state. A write at the same edge as the CMP compare is not seen by it; CMP uses the old ref.
- ack, hit and err are zero outside RESP. gnt is never multi-hot.

Optional Feature:
S38584_SCHED_TIMEOUT_EN
- Defined:
  - A counter of width ceil(log2(TO_CYCLES+1)) clears on entry to GRANT and increments each cycle spent in GRANT.
  - When it reaches TO_CYCLES while still in GRANT, the FSM goes to RESP with err=1, hit=0.
  - TO_CYCLES=15 means the 16th GRANT cycle forces exit.
- Undefined: no counter; GRANT waits indefinitely, and only a req drop or reset exits it.

Decomposition:
- Package s38584_sched_pkg holds the state enum (IDLE, GRANT, CMP, RESP), default NREQ/KW/TO_CYCLES constants, and a clog2 helper.
- One sub-module, s38584_rr_arb: combinational round-robin pick (req, pointer → one-hot winner plus index).
- FSM, counter, status and reference registers stay in the top.

Test Plan:
1. Reset then ref=2'b10, req=4'b0100, tag[2]=2'b10, tag_vld held → gnt=4'b0100 at t+1, ack=1 and hit=1 at t+3, stat=4'b0100.
2. req=4'b1111 held, all tags matching, tag_vld held → gnt sequence 0001, 0010, 0100, 1000, 0001. Each ack has hit=1; stat toggles 1111 then back to 0000 after 8 acks.
3. Grant to 0, drop req[0] in GRANT → ack=1, err=1, hit=0, stat unchanged; the next grant goes to requester 1 if pending.
4. inhibit=1 with req=4'b0011 for 5 cycles → gnt=0, busy=0. Drop inhibit → gnt=4'b0001 the next cycle. Raise inhibit during CMP → ack still issued.
5. cfg_we with cfg_ref=2'b01 on the CMP edge, captured tag=2'b01, old ref=2'b00 → hit=0. A following identical transaction → hit=1.
6. With S38584_SCHED_TIMEOUT_EN, TO_CYCLES=15, req held, tag_vld=0 → ack and err pulse after 16 GRANT cycles. Pulse g35 low during GRANT → gnt=0, no ack.
